// File: rtl/gate_pkg.sv
// Shared definitions for the registered bitwise gate unit.
// Provides the gate opcode enum and its width.
package gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise gate: y = f(left, right) for one of eight ops.
// Ports: left/right WIDTH-bit operands, op gate select, y WIDTH-bit result.
module gate_alu
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  gate_op_e         op,
  output logic [WIDTH-1:0] y
);

  // NOT and BUF never look at right, so a garbage
  // right operand cannot leak into their result.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = left & right;
      OP_OR:   y = left | right;
      OP_NAND: y = ~(left & right);
      OP_NOR:  y = ~(left | right);
      OP_XOR:  y = left ^ right;
      OP_XNOR: y = ~(left ^ right);
      OP_NOT:  y = ~left;
      OP_BUF:  y = left;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit_pipe.sv
// Registered gate unit: one-entry output register with valid/ready on
// both sides, optional accumulate chaining and an accepted-beat counter.
// Ports: clk, rst_n (async low); in_valid/in_ready, in_a, in_b, in_op,
// in_acc; out_valid/out_ready, out_y, out_zero, out_ones; beat_cnt.
module gate_unit_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ones_q, out_ones_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             accept;
  logic [WIDTH-1:0] left, right, res;

  // Ready depends only on the output side, never on in_valid.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign left  = in_acc ? acc_q : in_a;
  assign right = in_acc ? in_a  : in_b;

  gate_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .left (left),
    .right(right),
    .op   (gate_op_e'(in_op)),
    .y    (res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_zero_d  = out_zero_q;
    out_ones_d  = out_ones_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    if (accept) begin
      // A pop in the same cycle is simply overwritten.
      out_valid_d = 1'b1;
      out_y_d     = res;
      out_zero_d  = ~|res;
      out_ones_d  = &res;
      acc_d       = res;
      beat_cnt_d  = beat_cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_zero_q  <= 1'b1;
      out_ones_q  <= 1'b0;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_zero_q  <= out_zero_d;
      out_ones_q  <= out_ones_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_zero  = out_zero_q;
  assign out_ones  = out_ones_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
